// File: rtl/spm_lane_reassembly_unit.sv
// rtl/spm_lane_reassembly_unit.sv - scratchpad read-path lane reassembly (bank -> lane steering)
//
// Purpose:
//   Collects per-bank read words over one or more conflict-serialised beats,
//   steers each bank word back to the lane that requested it, and presents one
//   lane-ordered vector per request through a valid/ready handshake.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/ready    beat handshake from the bank array side
//   in_first/last     request framing of the current beat
//   in_req_mask       active lanes of the request (used on a first beat only)
//   in_lane_mask      lanes served by this beat
//   in_lane_bank      per-lane bank index, BANK_W bits per lane
//   in_bank_data      read word of every bank, DATA_WIDTH bits per bank
//   out_valid/ready   vector handshake toward core writeback
//   out_data          lane-ordered data (unserved / inactive lanes read 0)
//   out_req_mask      request mask of the held vector
//   out_miss_mask     active lanes that were never served
//   protocol_error    one-cycle pulse after a framing violation is accepted

module spm_lane_reassembly_unit #(
  parameter int NUM_LANES  = 16,
  parameter int NUM_BANKS  = 16,
  parameter int DATA_WIDTH = 32,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [NUM_LANES-1:0]            in_req_mask,
  input  logic [NUM_LANES-1:0]            in_lane_mask,
  input  logic [NUM_LANES*BANK_W-1:0]     in_lane_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] in_bank_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_req_mask,
  output logic [NUM_LANES-1:0]            out_miss_mask,
  output logic                            protocol_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] data_d [NUM_LANES];
  logic [NUM_LANES-1:0]  req_q, req_d;
  logic [NUM_LANES-1:0]  served_q, served_d;
  logic                  err_q, err_d;

  logic                  acc;
  logic                  restart;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] bank_word [NUM_LANES];

  // Inverse remap: each lane picks the word of the bank it was mapped to.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [BANK_W-1:0] lane_bank;
    assign lane_bank    = in_lane_bank[l*BANK_W +: BANK_W];
    assign bank_word[l] = in_bank_data[int'(lane_bank)*DATA_WIDTH +: DATA_WIDTH];
    assign out_data[l*DATA_WIDTH +: DATA_WIDTH] = data_q[l];
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    req_d    = req_q;
    served_d = served_q;
    err_d    = 1'b0;
    restart  = 1'b0;
    wr_en    = 1'b0;

    // Only one vector of storage: while holding, a beat can enter only in the
    // same cycle the held vector leaves.
    in_ready = (state_q == HOLD) ? out_ready : 1'b1;
    acc      = in_valid & in_ready;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_first) begin
            restart = 1'b1;
            state_d = in_last ? HOLD : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (acc) begin
          if (in_first) begin
            // Abandon the partial request and restart from this beat.
            err_d   = 1'b1;
            restart = 1'b1;
            state_d = in_last ? HOLD : COLLECT;
          end else begin
            wr_en = 1'b1;
            if (in_last) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (!acc) begin
            state_d = IDLE;
          end else if (in_first) begin
            restart = 1'b1;
            state_d = in_last ? HOLD : COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      for (int l = 0; l < NUM_LANES; l++) data_d[l] = '0;
      served_d = '0;
      req_d    = in_req_mask;
      wr_en    = 1'b1;
    end

    // req_d already holds the fresh mask on a first beat, the stored one otherwise.
    if (wr_en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (in_lane_mask[l] && req_d[l]) begin
          data_d[l]   = bank_word[l];
          served_d[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      served_q <= '0;
      err_q    <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      served_q <= served_d;
      err_q    <= err_d;
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= data_d[l];
    end
  end

  assign out_valid      = (state_q == HOLD);
  assign out_req_mask   = req_q;
  assign out_miss_mask  = req_q & ~served_q;
  assign protocol_error = err_q;

endmodule
